// File: rtl/reorder_buffer_mw.sv
// Circular reorder buffer: one dispatch port, NUM_CDB completion channels,
// in-order single commit per cycle, flush on a committing mispredicted branch.
module reorder_buffer_mw #(
  parameter int DEPTH      = 16,
  parameter int NUM_CDB    = 2,
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_dispatch_valid,
  output logic                      o_dispatch_ready,
  input  logic                      i_dispatch_has_dest,
  input  logic [AREG_WIDTH-1:0]     i_dispatch_areg,
  input  logic [PREG_WIDTH-1:0]     i_dispatch_preg,
  input  logic [PREG_WIDTH-1:0]     i_dispatch_old_preg,
  input  logic                      i_dispatch_is_store,
  output logic [TAG_W-1:0]          o_dispatch_tag,
  input  logic [NUM_CDB-1:0]        i_cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  i_cdb_tag,
  input  logic [NUM_CDB-1:0]        i_cdb_mispredict,
  input  logic [NUM_CDB*32-1:0]     i_cdb_target,
  input  logic                      i_store_ready,
  output logic                      o_commit_valid,
  output logic                      o_commit_has_dest,
  output logic [AREG_WIDTH-1:0]     o_commit_areg,
  output logic [PREG_WIDTH-1:0]     o_commit_preg,
  output logic [PREG_WIDTH-1:0]     o_commit_old_preg,
  output logic                      o_commit_is_store,
  output logic                      o_flush,
  output logic [31:0]               o_flush_pc,
  output logic [TAG_W:0]            o_count,
  output logic                      o_empty
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]      head;
  logic [TAG_W-1:0]      tail;
  logic [TAG_W:0]        count;
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      done_q;
  logic [DEPTH-1:0]      mispred_q;
  logic [DEPTH-1:0]      has_dest_q;
  logic [DEPTH-1:0]      is_store_q;
  logic [AREG_WIDTH-1:0] areg_q   [DEPTH];
  logic [PREG_WIDTH-1:0] preg_q   [DEPTH];
  logic [PREG_WIDTH-1:0] old_q    [DEPTH];
  logic [31:0]           target_q [DEPTH];

  logic             dispatch_fire;
  logic             commit_fire;
  logic             flush;
  logic [DEPTH-1:0] cdb_done;
  logic [DEPTH-1:0] cdb_mispred;

  assign commit_fire = !rst && valid_q[head] && done_q[head] &&
                       (!is_store_q[head] || i_store_ready);
  assign flush         = commit_fire && mispred_q[head];
  assign dispatch_fire = i_dispatch_valid && o_dispatch_ready;

  assign o_dispatch_ready  = !rst && (count != FULL_COUNT) && !flush;
  assign o_dispatch_tag    = tail;
  assign o_commit_valid    = commit_fire;
  assign o_commit_has_dest = has_dest_q[head];
  assign o_commit_areg     = areg_q[head];
  assign o_commit_preg     = preg_q[head];
  assign o_commit_old_preg = old_q[head];
  assign o_commit_is_store = is_store_q[head];
  assign o_flush           = flush;
  assign o_flush_pc        = flush ? target_q[head] : 32'd0;
  assign o_count           = rst ? '0 : count;
  assign o_empty           = rst || (count == '0);

  // Completion: per-entry done/mispredict set vectors, only for live entries
  always_comb begin
    cdb_done    = '0;
    cdb_mispred = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (i_cdb_valid[c] && valid_q[i_cdb_tag[c*TAG_W +: TAG_W]]) begin
        cdb_done[i_cdb_tag[c*TAG_W +: TAG_W]] = 1'b1;
        if (i_cdb_mispredict[c])
          cdb_mispred[i_cdb_tag[c*TAG_W +: TAG_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      done_q    <= done_q | cdb_done;
      mispred_q <= mispred_q | cdb_mispred;
      if (dispatch_fire) begin
        valid_q[tail]   <= 1'b1;
        done_q[tail]    <= 1'b0;
        mispred_q[tail] <= 1'b0;
        tail            <= tail + TAG_W'(1);
      end
      if (commit_fire) begin
        valid_q[head] <= 1'b0;
        head          <= head + TAG_W'(1);
      end
      count <= count + (TAG_W+1)'(dispatch_fire) - (TAG_W+1)'(commit_fire);
    end
  end

  // Payload storage carries no reset; the valid bits qualify it.
  // Channels are walked high to low so the lowest mispredicting channel's target lands last.
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      has_dest_q[tail] <= i_dispatch_has_dest;
      is_store_q[tail] <= i_dispatch_is_store;
      areg_q[tail]     <= i_dispatch_areg;
      preg_q[tail]     <= i_dispatch_preg;
      old_q[tail]      <= i_dispatch_old_preg;
    end
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (!rst && !flush && i_cdb_valid[c] && i_cdb_mispredict[c] &&
          valid_q[i_cdb_tag[c*TAG_W +: TAG_W]])
        target_q[i_cdb_tag[c*TAG_W +: TAG_W]] <= i_cdb_target[c*32 +: 32];
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Self-checking bench for reorder_buffer_mw: commit-order scoreboard, a
// completion vector table, and hand sequences for fill/drain, flush, stall, reset.
module tb_reorder_buffer_mw;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_dispatch_valid;
  logic        o_dispatch_ready;
  logic        i_dispatch_has_dest;
  logic [4:0]  i_dispatch_areg;
  logic [5:0]  i_dispatch_preg;
  logic [5:0]  i_dispatch_old_preg;
  logic        i_dispatch_is_store;
  logic [3:0]  o_dispatch_tag;
  logic [1:0]  i_cdb_valid;
  logic [7:0]  i_cdb_tag;
  logic [1:0]  i_cdb_mispredict;
  logic [63:0] i_cdb_target;
  logic        i_store_ready;
  logic        o_commit_valid;
  logic        o_commit_has_dest;
  logic [4:0]  o_commit_areg;
  logic [5:0]  o_commit_preg;
  logic [5:0]  o_commit_old_preg;
  logic        o_commit_is_store;
  logic        o_flush;
  logic [31:0] o_flush_pc;
  logic [4:0]  o_count;
  logic        o_empty;

  reorder_buffer_mw dut (
    .clk(clk), .rst(rst),
    .i_dispatch_valid(i_dispatch_valid), .o_dispatch_ready(o_dispatch_ready),
    .i_dispatch_has_dest(i_dispatch_has_dest), .i_dispatch_areg(i_dispatch_areg),
    .i_dispatch_preg(i_dispatch_preg), .i_dispatch_old_preg(i_dispatch_old_preg),
    .i_dispatch_is_store(i_dispatch_is_store), .o_dispatch_tag(o_dispatch_tag),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag),
    .i_cdb_mispredict(i_cdb_mispredict), .i_cdb_target(i_cdb_target),
    .i_store_ready(i_store_ready),
    .o_commit_valid(o_commit_valid), .o_commit_has_dest(o_commit_has_dest),
    .o_commit_areg(o_commit_areg), .o_commit_preg(o_commit_preg),
    .o_commit_old_preg(o_commit_old_preg), .o_commit_is_store(o_commit_is_store),
    .o_flush(o_flush), .o_flush_pc(o_flush_pc), .o_count(o_count), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       has_dest;
    logic [4:0] areg;
    logic [5:0] preg;
    logic [5:0] old;
    logic       is_store;
  } pl_t;

  typedef struct {
    bit       disp;
    bit [1:0] cv;
    bit [3:0] t0;
    bit [3:0] t1;
    bit       exp_cv;
    int       exp_cnt;
    int       exp_tag;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   seq = 0;
  int   n_commit = 0;
  int   base;
  pl_t  pend;
  pl_t  sb[$];
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic pl_t make_payload(input int s, input bit st);
    pl_t p;
    p.has_dest = s[0];
    p.areg     = s[4:0];
    p.preg     = 6'(s * 3 + 1);
    p.old      = 6'(s + 40);
    p.is_store = st;
    return p;
  endfunction

  task automatic drive_disp(input bit v, input bit st);
    pend                = make_payload(seq, st);
    i_dispatch_valid    = v;
    i_dispatch_has_dest = pend.has_dest;
    i_dispatch_areg     = pend.areg;
    i_dispatch_preg     = pend.preg;
    i_dispatch_old_preg = pend.old;
    i_dispatch_is_store = pend.is_store;
  endtask

  task automatic cdb(input bit [1:0] v, input bit [3:0] t0, input bit [3:0] t1,
                     input bit [1:0] mis, input logic [31:0] a, input logic [31:0] b);
    i_cdb_valid      = v;
    i_cdb_tag        = {t1, t0};
    i_cdb_mispredict = mis;
    i_cdb_target     = {b, a};
  endtask

  // One clock: record accepted dispatches, score any commit, then cross the posedge.
  task automatic tick();
    pl_t e;
    #1;
    if (i_dispatch_valid && o_dispatch_ready) begin
      sb.push_back(pend);
      seq++;
    end
    if (o_commit_valid) begin
      n_commit++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL commit_unexpected actual=commit expected=no_commit");
      end else begin
        e = sb.pop_front();
        chk("commit_fields",
            32'({o_commit_has_dest, o_commit_areg, o_commit_preg, o_commit_old_preg, o_commit_is_store}),
            32'(e));
      end
      if (o_flush) sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_disp(0, 0);
    cdb(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 2'b00, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 2'b00, 0, 0, 0, 1, 1};
    vecs[2]  = '{1, 2'b00, 0, 0, 0, 2, 2};
    vecs[3]  = '{0, 2'b01, 2, 0, 0, 3, -1};
    vecs[4]  = '{0, 2'b01, 1, 0, 0, 3, -1};
    vecs[5]  = '{0, 2'b01, 0, 0, 0, 3, -1};
    vecs[6]  = '{0, 2'b00, 0, 0, 1, 3, -1};
    vecs[7]  = '{0, 2'b00, 0, 0, 1, 2, -1};
    vecs[8]  = '{0, 2'b00, 0, 0, 1, 1, -1};
    vecs[9]  = '{0, 2'b00, 0, 0, 0, 0, -1};
    vecs[10] = '{1, 2'b00, 0, 0, 0, 0, 3};
    vecs[11] = '{1, 2'b00, 0, 0, 0, 1, 4};
    vecs[12] = '{1, 2'b00, 0, 0, 0, 2, 5};
    vecs[13] = '{0, 2'b11, 3, 5, 0, 3, -1};
    vecs[14] = '{0, 2'b11, 4, 4, 1, 3, -1};
    vecs[15] = '{0, 2'b00, 0, 0, 1, 2, -1};
    vecs[16] = '{0, 2'b00, 0, 0, 1, 1, -1};
    vecs[17] = '{0, 2'b00, 0, 0, 0, 0, -1};

    rst = 1'b1;
    i_store_ready = 1'b1;
    drive_disp(0, 0);
    cdb(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset state while rst is still high
    chk("rst_ready", o_dispatch_ready, 0);
    chk("rst_commit_valid", o_commit_valid, 0);
    chk("rst_flush", o_flush, 0);
    chk("rst_flush_pc", o_flush_pc, 0);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    do_reset();
    #1;
    chk("post_rst_ready", o_dispatch_ready, 1);
    chk("post_rst_tag", o_dispatch_tag, 0);

    // Out-of-order and dual-channel completion table
    for (int i = 0; i < 18; i++) begin
      drive_disp(vecs[i].disp, 0);
      cdb(vecs[i].cv, vecs[i].t0, vecs[i].t1, 0, 0, 0);
      #1;
      chk($sformatf("vec%0d_commit_valid", i), o_commit_valid, vecs[i].exp_cv);
      chk($sformatf("vec%0d_count", i), o_count, vecs[i].exp_cnt);
      if (vecs[i].disp) chk($sformatf("vec%0d_tag", i), o_dispatch_tag, vecs[i].exp_tag);
      tick();
    end
    cdb(0, 0, 0, 0, 0, 0);

    // Fill to 16, confirm full blocks dispatch, then drain in order with wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_disp(1, 0);
      #1;
      chk($sformatf("fill_tag%0d", i), o_dispatch_tag, i);
      tick();
    end
    drive_disp(1, 0);
    #1;
    chk("full_ready", o_dispatch_ready, 0);
    chk("full_count", o_count, 16);
    tick();
    base = n_commit;
    for (int k = 0; k < 16; k++) begin
      drive_disp(k == 1, 0);
      cdb(1, 4'(k), 0, 0, 0, 0);
      #1;
      chk($sformatf("drain%0d_commit_valid", k), o_commit_valid, k > 0);
      if (k == 1) chk("full_commit_ready", o_dispatch_ready, 0);
      tick();
    end
    drive_disp(0, 0);
    cdb(0, 0, 0, 0, 0, 0);
    #1;
    chk("drain_last_commit", o_commit_valid, 1);
    tick();
    #1;
    chk("drain_empty", o_empty, 1);
    chk("drain_count", o_count, 0);
    chk("drain_wrap_tag", o_dispatch_tag, 0);
    chk("drain_commits", n_commit - base, 16);

    // Mispredict flush, lowest channel target wins
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_disp(1, 0);
      tick();
    end
    drive_disp(0, 0);
    cdb(2'b11, 0, 1, 0, 0, 0);
    tick();
    cdb(2'b11, 2, 2, 2'b11, 32'h0040_0100, 32'h0BAD_0000);
    #1;
    chk("mp_c0_commit", o_commit_valid, 1);
    chk("mp_c0_flush", o_flush, 0);
    tick();
    cdb(0, 0, 0, 0, 0, 0);
    #1;
    chk("mp_c1_commit", o_commit_valid, 1);
    chk("mp_c1_flush", o_flush, 0);
    tick();
    drive_disp(1, 0);
    cdb(2'b01, 3, 0, 0, 0, 0);
    #1;
    chk("mp_c2_commit", o_commit_valid, 1);
    chk("mp_c2_flush", o_flush, 1);
    chk("mp_c2_flush_pc", o_flush_pc, 32'h0040_0100);
    chk("mp_c2_ready", o_dispatch_ready, 0);
    tick();
    drive_disp(0, 0);
    cdb(0, 0, 0, 0, 0, 0);
    #1;
    chk("mp_after_count", o_count, 0);
    chk("mp_after_tag", o_dispatch_tag, 0);
    chk("mp_after_ready", o_dispatch_ready, 1);
    chk("mp_after_commit", o_commit_valid, 0);
    chk("mp_after_sb", sb.size(), 0);
    drive_disp(1, 0);
    tick();
    drive_disp(0, 0);
    cdb(2'b01, 0, 0, 0, 0, 0);
    #1;
    chk("mp_new_not_done", o_commit_valid, 0);
    tick();
    cdb(0, 0, 0, 0, 0, 0);
    #1;
    chk("mp_new_commit", o_commit_valid, 1);
    chk("mp_new_no_flush", o_flush, 0);
    tick();

    // Store stall at head
    do_reset();
    i_store_ready = 1'b0;
    drive_disp(1, 1);
    tick();
    drive_disp(1, 0);
    tick();
    drive_disp(0, 0);
    cdb(2'b11, 0, 1, 0, 0, 0);
    tick();
    cdb(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stall%0d_commit", i), o_commit_valid, 0);
      chk($sformatf("stall%0d_count", i), o_count, 2);
      tick();
    end
    i_store_ready = 1'b1;
    #1;
    chk("stall_release_commit", o_commit_valid, 1);
    chk("stall_release_is_store", o_commit_is_store, 1);
    tick();
    #1;
    chk("stall_younger_commit", o_commit_valid, 1);
    tick();
    #1;
    chk("stall_empty", o_empty, 1);

    // Reset with live entries, a completion and a dispatch in the same cycle
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_disp(1, 0);
      tick();
    end
    rst = 1'b1;
    drive_disp(1, 0);
    cdb(2'b01, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_ready", o_dispatch_ready, 0);
    chk("midrst_commit", o_commit_valid, 0);
    tick();
    rst = 1'b0;
    sb.delete();
    drive_disp(0, 0);
    cdb(0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_count", o_count, 0);
    chk("midrst_empty", o_empty, 1);
    chk("midrst_no_commit", o_commit_valid, 0);
    chk("midrst_no_flush", o_flush, 0);
    chk("midrst_ready_after", o_dispatch_ready, 1);
    tick();
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
